tex_req_agent: RTL and testbench

Core-side initiator for the texture bus. Accepts texture-sample instructions from the execute stage and issues requests to the texture unit. Tracks in-flight requests in a pending table, matches out-of-order responses by tag, and returns texels with their warp metadata to the commit stage. Sits between the SFU/execute dispatch and the texture unit's request/response bus.

---
 rtl/tex_agent_pkg.sv | 48 ++++
 rtl/tex_req_agent_if.sv | 66 ++++++
 rtl/tex_pending_table.sv | 59 +++++
 rtl/tex_req_agent.sv | 125 ++++++++++++
 tb/tb_tex_req_agent.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tex_agent_pkg.sv
// Shared types and sizing for the texture request agent and its pending table.
package tex_agent_pkg;

    localparam int unsigned NUM_LANES   = 4;
    localparam int unsigned NUM_WARPS   = 8;
    localparam int unsigned NUM_PENDING = 8;
    localparam int unsigned UUID_WIDTH  = 44;
    localparam int unsigned STAGE_BITS  = 1;
    localparam int unsigned LOD_BITS    = 4;

    localparam int unsigned WID_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int unsigned IDX_W   = $clog2(NUM_PENDING);
    localparam int unsigned TAG_W   = UUID_WIDTH + IDX_W;
    localparam int unsigned COORD_W = 2 * NUM_LANES * 32;
    localparam int unsigned LOD_W   = NUM_LANES * LOD_BITS;
    localparam int unsigned DATA_W  = NUM_LANES * 32;

    typedef struct packed {
        logic [WID_W-1:0]     wid;
        logic [NUM_LANES-1:0] tmask;
        logic [31:0]          pc;
        logic [4:0]           rd;
    } tex_agent_meta_t;

    typedef struct packed {
        logic [NUM_LANES-1:0]  mask;
        logic [COORD_W-1:0]    coords;
        logic [LOD_W-1:0]      lod;
        logic [STAGE_BITS-1:0] stage;
        logic [TAG_W-1:0]      tag;
    } tex_agent_req_t;

    typedef struct packed {
        logic [UUID_WIDTH-1:0] uuid;
        tex_agent_meta_t       meta;
        logic [DATA_W-1:0]     data;
    } tex_agent_commit_t;

    // Tag layout is {uuid, idx}; the table index lives in the low bits.
    function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] tag);
        return tag[IDX_W-1:0];
    endfunction

    function automatic logic [UUID_WIDTH-1:0] tag_uuid(input logic [TAG_W-1:0] tag);
        return tag[TAG_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/tex_req_agent_if.sv
// Bus bundle for the texture request agent: execute input, texture request/response, commit.
interface tex_req_agent_if;
    import tex_agent_pkg::*;

    logic                  exe_req_valid;
    logic                  exe_req_ready;
    logic [UUID_WIDTH-1:0] exe_req_uuid;
    logic [WID_W-1:0]      exe_req_wid;
    logic [NUM_LANES-1:0]  exe_req_tmask;
    logic [31:0]           exe_req_pc;
    logic [4:0]            exe_req_rd;
    logic [STAGE_BITS-1:0] exe_req_stage;
    logic [COORD_W-1:0]    exe_req_coords;
    logic [LOD_W-1:0]      exe_req_lod;

    logic                  tex_req_valid;
    logic                  tex_req_ready;
    logic [NUM_LANES-1:0]  tex_req_mask;
    logic [COORD_W-1:0]    tex_req_coords;
    logic [LOD_W-1:0]      tex_req_lod;
    logic [STAGE_BITS-1:0] tex_req_stage;
    logic [TAG_W-1:0]      tex_req_tag;

    logic                  tex_rsp_valid;
    logic                  tex_rsp_ready;
    logic [DATA_W-1:0]     tex_rsp_texels;
    logic [TAG_W-1:0]      tex_rsp_tag;

    logic                  commit_valid;
    logic                  commit_ready;
    logic [UUID_WIDTH-1:0] commit_uuid;
    logic [WID_W-1:0]      commit_wid;
    logic [NUM_LANES-1:0]  commit_tmask;
    logic [31:0]           commit_pc;
    logic [4:0]            commit_rd;
    logic [DATA_W-1:0]     commit_data;

    modport master (
        input  exe_req_valid, exe_req_uuid, exe_req_wid, exe_req_tmask, exe_req_pc,
               exe_req_rd, exe_req_stage, exe_req_coords, exe_req_lod,
        output exe_req_ready,
        output tex_req_valid, tex_req_mask, tex_req_coords, tex_req_lod, tex_req_stage,
               tex_req_tag,
        input  tex_req_ready,
        input  tex_rsp_valid, tex_rsp_texels, tex_rsp_tag,
        output tex_rsp_ready,
        output commit_valid, commit_uuid, commit_wid, commit_tmask, commit_pc, commit_rd,
               commit_data,
        input  commit_ready
    );

    modport slave (
        output exe_req_valid, exe_req_uuid, exe_req_wid, exe_req_tmask, exe_req_pc,
               exe_req_rd, exe_req_stage, exe_req_coords, exe_req_lod,
        input  exe_req_ready,
        input  tex_req_valid, tex_req_mask, tex_req_coords, tex_req_lod, tex_req_stage,
               tex_req_tag,
        output tex_req_ready,
        output tex_rsp_valid, tex_rsp_texels, tex_rsp_tag,
        input  tex_rsp_ready,
        input  commit_valid, commit_uuid, commit_wid, commit_tmask, commit_pc, commit_rd,
               commit_data,
        output commit_ready
    );

endinterface

// File: rtl/tex_pending_table.sv
// In-flight request table: free mask, lowest-free allocator, metadata store and occupancy count.
module tex_pending_table
    import tex_agent_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_en,
    input  tex_agent_meta_t  alloc_meta,
    output logic [IDX_W-1:0] alloc_idx,
    output logic             full,
    input  logic             rel_en,
    input  logic [IDX_W-1:0] rel_idx,
    output tex_agent_meta_t  rel_meta,
    output logic [IDX_W:0]   count
);

    logic [NUM_PENDING-1:0] free_q;
    logic [IDX_W:0]         count_q;
    tex_agent_meta_t        meta_q [NUM_PENDING];

    // Scan from the top so the lowest free index wins; uses the pre-update mask only.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_PENDING - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign full     = (free_q == '0);
    assign rel_meta = meta_q[rel_idx];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            free_q  <= '1;
            count_q <= '0;
        end else begin
            if (alloc_en) begin
                free_q[alloc_idx] <= 1'b0;
            end
            if (rel_en) begin
                free_q[rel_idx] <= 1'b1;
            end
            count_q <= count_q + (IDX_W + 1)'(alloc_en) - (IDX_W + 1)'(rel_en);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en) begin
            meta_q[alloc_idx] <= alloc_meta;
        end
    end

    rel_idx_allocated: assert property (@(posedge clk) disable iff (reset)
        rel_en |-> !free_q[rel_idx]);

endmodule

// File: rtl/tex_req_agent.sv
// Core-side texture bus initiator: issues tagged requests, matches out-of-order responses to commit.
module tex_req_agent
    import tex_agent_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    tex_req_agent_if.master bus,
    output logic [IDX_W:0]  pending_count,
    output logic            idle
);

    logic              full;
    logic [IDX_W-1:0]  alloc_idx;
    logic              req_can_accept;
    logic              exe_fire;
    logic              rsp_fire;
    logic              out_free;
    tex_agent_meta_t   alloc_meta;
    tex_agent_meta_t   rsp_meta;
    tex_agent_commit_t rsp_entry;

    logic              req_valid_q;
    tex_agent_req_t    req_q;
    logic              out_valid_q;
    tex_agent_commit_t out_q;
    logic              skid_valid_q;
    tex_agent_commit_t skid_q;

    assign req_can_accept    = !req_valid_q || bus.tex_req_ready;
    assign bus.exe_req_ready = !full && req_can_accept;
    assign exe_fire          = bus.exe_req_valid && bus.exe_req_ready;

    // Skid slot empty means one more response always has somewhere to land.
    assign bus.tex_rsp_ready = !skid_valid_q;
    assign rsp_fire          = bus.tex_rsp_valid && bus.tex_rsp_ready;
    assign out_free          = !out_valid_q || bus.commit_ready;

    assign alloc_meta = '{
        wid:   bus.exe_req_wid,
        tmask: bus.exe_req_tmask,
        pc:    bus.exe_req_pc,
        rd:    bus.exe_req_rd
    };

    assign rsp_entry = '{
        uuid: tag_uuid(bus.tex_rsp_tag),
        meta: rsp_meta,
        data: bus.tex_rsp_texels
    };

    tex_pending_table u_table (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (exe_fire),
        .alloc_meta (alloc_meta),
        .alloc_idx  (alloc_idx),
        .full       (full),
        .rel_en     (rsp_fire),
        .rel_idx    (tag_idx(bus.tex_rsp_tag)),
        .rel_meta   (rsp_meta),
        .count      (pending_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
        end else if (exe_fire) begin
            req_valid_q <= 1'b1;
            req_q       <= '{
                mask:   bus.exe_req_tmask,
                coords: bus.exe_req_coords,
                lod:    bus.exe_req_lod,
                stage:  bus.exe_req_stage,
                tag:    {bus.exe_req_uuid, alloc_idx}
            };
        end else if (bus.tex_req_ready) begin
            req_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= rsp_fire;
                if (rsp_fire) begin
                    out_q <= rsp_entry;
                end
            end
        end else if (rsp_fire) begin
            skid_valid_q <= 1'b1;
            skid_q       <= rsp_entry;
        end
    end

    assign bus.tex_req_valid  = req_valid_q;
    assign bus.tex_req_mask   = req_q.mask;
    assign bus.tex_req_coords = req_q.coords;
    assign bus.tex_req_lod    = req_q.lod;
    assign bus.tex_req_stage  = req_q.stage;
    assign bus.tex_req_tag    = req_q.tag;

    assign bus.commit_valid = out_valid_q;
    assign bus.commit_uuid  = out_q.uuid;
    assign bus.commit_wid   = out_q.meta.wid;
    assign bus.commit_tmask = out_q.meta.tmask;
    assign bus.commit_pc    = out_q.meta.pc;
    assign bus.commit_rd    = out_q.meta.rd;
    assign bus.commit_data  = out_q.data;

    assign idle = (pending_count == '0) && !req_valid_q && !out_valid_q;

    exe_tmask_nonzero: assert property (@(posedge clk) disable iff (reset)
        bus.exe_req_valid |-> (bus.exe_req_tmask != '0));

endmodule

// File: tb/tb_tex_req_agent.sv
// Directed bench for tex_req_agent: issue, fill, out-of-order, backpressure and reset.
module tb_tex_req_agent;
    import tex_agent_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic [IDX_W:0] pending_count;
    logic           idle;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    tex_req_agent_if bus ();

    tex_req_agent dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .pending_count (pending_count),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TAG_W-1:0] mk_tag(input int uuid, input int idx);
        return {UUID_WIDTH'(uuid), IDX_W'(idx)};
    endfunction

    task automatic set_req(input int uuid, input int wid, input logic [3:0] tmask,
                           input logic [31:0] pc, input int rd);
        bus.exe_req_valid  = 1'b1;
        bus.exe_req_uuid   = UUID_WIDTH'(uuid);
        bus.exe_req_wid    = WID_W'(wid);
        bus.exe_req_tmask  = tmask;
        bus.exe_req_pc     = pc;
        bus.exe_req_rd     = 5'(rd);
        bus.exe_req_stage  = STAGE_BITS'(rd % 2);
        bus.exe_req_coords = {8{pc}};
        bus.exe_req_lod    = {4{4'(rd)}};
    endtask

    task automatic send_rsp(input int uuid, input int idx, input logic [31:0] texel);
        bus.tex_rsp_valid  = 1'b1;
        bus.tex_rsp_tag    = mk_tag(uuid, idx);
        bus.tex_rsp_texels = {4{texel}};
    endtask

    int          oo_idx  [4] = '{3, 0, 2, 1};
    int          oo_uuid [4] = '{19, 16, 99, 17};
    int          oo_rd   [4] = '{3, 0, 9, 1};
    logic [31:0] oo_pc   [4] = '{32'h100C, 32'h1000, 32'h2000, 32'h1004};

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] tx;
        reset              = 1'b1;
        bus.exe_req_valid  = 1'b0;
        bus.exe_req_uuid   = '0;
        bus.exe_req_wid    = '0;
        bus.exe_req_tmask  = '0;
        bus.exe_req_pc     = '0;
        bus.exe_req_rd     = '0;
        bus.exe_req_stage  = '0;
        bus.exe_req_coords = '0;
        bus.exe_req_lod    = '0;
        bus.tex_req_ready  = 1'b1;
        bus.tex_rsp_valid  = 1'b0;
        bus.tex_rsp_texels = '0;
        bus.tex_rsp_tag    = '0;
        bus.commit_ready   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_tex_req_valid", bus.tex_req_valid, 1'b0);
        check("rst_commit_valid", bus.commit_valid, 1'b0);
        check("rst_pending", pending_count, 0);
        check("rst_idle", idle, 1'b1);
        check("rst_exe_ready", bus.exe_req_ready, 1'b1);
        check("rst_rsp_ready", bus.tex_rsp_ready, 1'b1);

        // Single request / response round trip
        set_req(5, 3, 4'b1011, 32'h80000100, 7);
        #1 check("t1_exe_ready", bus.exe_req_ready, 1'b1);
        tick();
        bus.exe_req_valid = 1'b0;
        check("t1_req_valid", bus.tex_req_valid, 1'b1);
        check("t1_req_tag", bus.tex_req_tag, mk_tag(5, 0));
        check("t1_req_mask", bus.tex_req_mask, 4'b1011);
        check("t1_req_stage", bus.tex_req_stage, 1'b1);
        check("t1_req_lod", bus.tex_req_lod, 16'h7777);
        check("t1_req_coords", bus.tex_req_coords, {8{32'h80000100}});
        check("t1_pending1", pending_count, 1);
        check("t1_idle_busy", idle, 1'b0);
        send_rsp(5, 0, 32'hAABBCCDD);
        tick();
        bus.tex_rsp_valid = 1'b0;
        check("t1_commit_valid", bus.commit_valid, 1'b1);
        check("t1_commit_uuid", bus.commit_uuid, 5);
        check("t1_commit_wid", bus.commit_wid, 3);
        check("t1_commit_tmask", bus.commit_tmask, 4'b1011);
        check("t1_commit_pc", bus.commit_pc, 32'h80000100);
        check("t1_commit_rd", bus.commit_rd, 7);
        check("t1_commit_data", bus.commit_data, {4{32'hAABBCCDD}});
        check("t1_pending0", pending_count, 0);
        check("t1_req_drained", bus.tex_req_valid, 1'b0);
        tick();
        check("t1_commit_done", bus.commit_valid, 1'b0);
        check("t1_idle_end", idle, 1'b1);

        // Fill the table
        for (int i = 0; i < 8; i++) begin
            set_req(16 + i, i, 4'(i + 1), 32'h1000 + 4 * i, i);
            #1 check($sformatf("fill_ready_%0d", i), bus.exe_req_ready, 1'b1);
            tick();
            check($sformatf("fill_tag_%0d", i), bus.tex_req_tag, mk_tag(16 + i, i));
        end
        check("fill_pending8", pending_count, 8);
        set_req(99, 1, 4'b0110, 32'h2000, 9);
        #1 check("fill_ready_9th", bus.exe_req_ready, 1'b0);
        tick();
        check("fill_pending_hold", pending_count, 8);
        check("fill_no_issue", bus.tex_req_valid, 1'b0);
        send_rsp(18, 2, 32'h11112222);
        #1 check("fill_rsp_ready", bus.tex_rsp_ready, 1'b1);
        tick();
        bus.tex_rsp_valid = 1'b0;
        check("fill_pending7", pending_count, 7);
        check("fill_commit_pc", bus.commit_pc, 32'h1008);
        check("fill_commit_uuid", bus.commit_uuid, 18);
        #1 check("fill_ready_after_free", bus.exe_req_ready, 1'b1);
        tick();
        bus.exe_req_valid = 1'b0;
        check("fill_reuse_tag", bus.tex_req_tag, mk_tag(99, 2));
        check("fill_pending_refill", pending_count, 8);

        // Same-cycle alloc and free with table full
        set_req(100, 2, 4'b1100, 32'h2004, 10);
        send_rsp(20, 4, 32'h44445555);
        #1 check("same_ready_full", bus.exe_req_ready, 1'b0);
        tick();
        bus.tex_rsp_valid = 1'b0;
        check("same_pending7", pending_count, 7);
        check("same_no_issue", bus.tex_req_valid, 1'b0);
        check("same_commit_uuid", bus.commit_uuid, 20);
        #1 check("same_ready_next", bus.exe_req_ready, 1'b1);
        tick();
        bus.exe_req_valid = 1'b0;
        check("same_tag_idx4", bus.tex_req_tag, mk_tag(100, 4));
        check("same_pending8", pending_count, 8);

        // Out-of-order responses
        for (int i = 0; i < 4; i++) begin
            tx = 32'hC0DE0000 + 32'(oo_idx[i]);
            send_rsp(oo_uuid[i], oo_idx[i], tx);
            tick();
            check($sformatf("ooo_valid_%0d", i), bus.commit_valid, 1'b1);
            check($sformatf("ooo_uuid_%0d", i), bus.commit_uuid, oo_uuid[i]);
            check($sformatf("ooo_pc_%0d", i), bus.commit_pc, oo_pc[i]);
            check($sformatf("ooo_rd_%0d", i), bus.commit_rd, oo_rd[i]);
            check($sformatf("ooo_data_%0d", i), bus.commit_data, {4{tx}});
            check($sformatf("ooo_pending_%0d", i), pending_count, 7 - i);
        end
        bus.tex_rsp_valid = 1'b0;
        tick();
        check("ooo_commit_done", bus.commit_valid, 1'b0);

        // Commit backpressure with three responses
        bus.commit_ready = 1'b0;
        send_rsp(21, 5, 32'h55550005);
        #1 check("cbp_rsp_ready_a", bus.tex_rsp_ready, 1'b1);
        tick();
        check("cbp_uuid_a", bus.commit_uuid, 21);
        check("cbp_pending3", pending_count, 3);
        send_rsp(22, 6, 32'h55550006);
        #1 check("cbp_rsp_ready_b", bus.tex_rsp_ready, 1'b1);
        tick();
        check("cbp_uuid_hold", bus.commit_uuid, 21);
        check("cbp_pending2", pending_count, 2);
        send_rsp(23, 7, 32'h55550007);
        #1 check("cbp_rsp_ready_drop", bus.tex_rsp_ready, 1'b0);
        tick();
        check("cbp_uuid_hold2", bus.commit_uuid, 21);
        check("cbp_valid_hold", bus.commit_valid, 1'b1);
        check("cbp_pending_hold", pending_count, 2);
        bus.commit_ready = 1'b1;
        tick();
        check("cbp_uuid_b", bus.commit_uuid, 22);
        check("cbp_rd_b", bus.commit_rd, 6);
        check("cbp_rsp_ready_back", bus.tex_rsp_ready, 1'b1);
        tick();
        bus.tex_rsp_valid = 1'b0;
        check("cbp_uuid_c", bus.commit_uuid, 23);
        check("cbp_data_c", bus.commit_data, {4{32'h55550007}});
        check("cbp_pending1", pending_count, 1);
        tick();
        check("cbp_commit_done", bus.commit_valid, 1'b0);

        // Texture request backpressure
        bus.tex_req_ready = 1'b0;
        set_req(200, 4, 4'b1111, 32'h3000, 11);
        #1 check("tbp_ready_first", bus.exe_req_ready, 1'b1);
        tick();
        check("tbp_tag_first", bus.tex_req_tag, mk_tag(200, 0));
        set_req(201, 5, 4'b0011, 32'h3004, 12);
        for (int c = 0; c < 5; c++) begin
            #1 check($sformatf("tbp_exe_stall_%0d", c), bus.exe_req_ready, 1'b0);
            tick();
            check($sformatf("tbp_tag_hold_%0d", c), bus.tex_req_tag, mk_tag(200, 0));
            check($sformatf("tbp_coords_hold_%0d", c), bus.tex_req_coords, {8{32'h3000}});
        end
        bus.tex_req_ready = 1'b1;
        #1 check("tbp_ready_release", bus.exe_req_ready, 1'b1);
        tick();
        check("tbp_tag_201", bus.tex_req_tag, mk_tag(201, 1));
        set_req(202, 6, 4'b1000, 32'h3008, 13);
        tick();
        bus.exe_req_valid = 1'b0;
        check("tbp_tag_202", bus.tex_req_tag, mk_tag(202, 2));
        check("tbp_pending4", pending_count, 4);
        tick();
        check("tbp_drained", bus.tex_req_valid, 1'b0);

        // Reset mid-stream
        bus.commit_ready  = 1'b0;
        bus.tex_req_ready = 1'b0;
        send_rsp(200, 0, 32'h77777777);
        set_req(203, 6, 4'b0101, 32'h300C, 14);
        tick();
        bus.tex_rsp_valid = 1'b0;
        bus.exe_req_valid = 1'b0;
        check("mrst_commit_busy", bus.commit_valid, 1'b1);
        check("mrst_req_busy", bus.tex_req_valid, 1'b1);
        check("mrst_pending4", pending_count, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_pending0", pending_count, 0);
        check("mrst_idle", idle, 1'b1);
        check("mrst_req_valid", bus.tex_req_valid, 1'b0);
        check("mrst_commit_valid", bus.commit_valid, 1'b0);
        check("mrst_rsp_ready", bus.tex_rsp_ready, 1'b1);
        bus.tex_req_ready = 1'b1;
        bus.commit_ready  = 1'b1;
        set_req(7, 0, 4'b0001, 32'h4000, 15);
        tick();
        bus.exe_req_valid = 1'b0;
        check("post_rst_tag", bus.tex_req_tag, mk_tag(7, 0));
        check("post_rst_pending", pending_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
